rca_serial_ctrl: RTL and testbench

//   Digit-serial multi-precision adder controller. Adds WIDTH-bit operands one 4-bit slice per

---
 rtl/rca_pkg.sv | 12 +
 rtl/rca_nibble.sv | 24 ++
 rtl/rca_serial_ctrl.sv | 145 ++++++++++++++
 tb/tb_rca_serial_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the digit-serial adder controller: slice width and FSM state encoding.
package rca_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_nibble.sv
// One 4-bit ripple-carry slice: purely combinational, carry ripples bit by bit from bit 0 upwards.
module rca_nibble
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               carry
);

    // Chain of full adders, LSB first.
    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry = c;
    end

endmodule

// File: rtl/rca_serial_ctrl.sv
// Digit-serial multi-precision adder controller.
// Adds two WIDTH-bit operands one nibble per cycle (LSB nibble first) through a single shared
// rca_nibble slice with a registered carry between passes.
// Operand side:  in_valid/in_ready  -- a transfer happens on a rising edge where both are 1.
// Result side:   out_valid/out_ready -- out_valid, sum and cout stay stable until a rising edge
//                where both are 1; the controller then returns to IDLE.
// Optional feature: define RCA_SUB_EN to add the sub input (a - b when sub=1, cin ignored).
// state_dbg mirrors the FSM state register for observation.
module rca_serial_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    // Reject widths that cannot be split into whole nibbles.
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("rca_serial_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;
    logic               start_carry;
`ifdef RCA_SUB_EN
    logic               sub_r;
`endif

    assign state_dbg = state;

    // Select the B nibble fed to the slice and the initial carry for the next operation.
    always_comb begin
        slice_b     = b_sh[SLICE_W-1:0];
        start_carry = cin;
`ifdef RCA_SUB_EN
        if (sub_r) begin
            slice_b = ~b_sh[SLICE_W-1:0];
        end
        if (sub) begin
            start_carry = 1'b1;
        end
`endif
    end

    rca_nibble u_slice (
        .a     (a_sh[SLICE_W-1:0]),
        .b     (slice_b),
        .cin   (carry),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    // Controller FSM with registered handshake/status outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
`ifdef RCA_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= start_carry;
                        cnt      <= '0;
`ifdef RCA_SUB_EN
                        sub_r    <= sub;
`endif
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            sum[i*SLICE_W +: SLICE_W] <= slice_sum;
                        end
                    end
                    carry <= slice_carry;
                    a_sh  <= a_sh >> SLICE_W;
                    b_sh  <= b_sh >> SLICE_W;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        cout      <= slice_carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Accept of the next operation is deferred to the cycle after this one.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_serial_ctrl.sv
// Bench for rca_serial_ctrl: table of directed operations on a WIDTH=16 instance plus hand-written
// sequences for backpressure, mid-run reset, back-to-back throughput and a WIDTH=4 instance.
module tb_rca_serial_ctrl;

    localparam int W       = 16;
    localparam int NIB     = W / 4;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           hold;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic [1:0]   state_dbg;
`ifdef RCA_SUB_EN
    logic         sub;
    logic         sub4;
`endif

    logic         in_valid4;
    logic         in_ready4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         cin4;
    logic         out_valid4;
    logic         out_ready4;
    logic [3:0]   sum4;
    logic         cout4;
    logic         busy4;
    logic [1:0]   state_dbg4;

    int total;
    int bad;

    // Clock and DUT instances.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rca_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    rca_serial_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef RCA_SUB_EN
        .sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4),
        .state_dbg (state_dbg4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation through the handshake, with optional result backpressure.
    task automatic run_op(input vec_t v);
        int n;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
`ifdef RCA_SUB_EN
        sub      = v.sub;
`endif
        tick();
        in_valid = 1'b0;
        a        = W'($urandom_range(0, 16'hFFFF));
        b        = W'($urandom_range(0, 16'hFFFF));
        cin      = 1'($urandom_range(0, 1));
        check("busy_run", {30'b0, busy, in_ready}, 32'h2);
        n = 0;
        while (!out_valid && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("latency", n, NIB);
        check("sum", {16'b0, sum}, {16'b0, v.exp_sum});
        check("cout", {31'b0, cout}, {31'b0, v.exp_cout});
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            tick();
            check("hold_valid", {30'b0, out_valid, in_ready}, 32'h2);
            check("hold_sum", {15'b0, cout, sum}, {15'b0, v.exp_cout, v.exp_sum});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release", {29'b0, out_valid, in_ready, busy}, 32'h2);
        check("release_state", {30'b0, state_dbg}, 32'd0);
    endtask

    vec_t vecs[10];
    int   nvec;
    int   acc_cyc[$];

    initial begin
        total = 0;
        bad   = 0;
        nvec  = 0;
        vecs[nvec++] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0};
        vecs[nvec++] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0};
        vecs[nvec++] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3};
        vecs[nvec++] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 0};
        vecs[nvec++] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1};
        vecs[nvec++] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
        vecs[nvec++] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 0};
`ifdef RCA_SUB_EN
        vecs[nvec++] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0};
        vecs[nvec++] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0};
        vecs[nvec++] = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0, 0};
        sub  = 1'b0;
        sub4 = 1'b0;
`endif

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        out_ready4 = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_flags", {29'b0, in_ready, out_valid, busy}, 32'h4);
        check("rst_sum", {15'b0, cout, sum}, 32'd0);
        check("rst_state", {30'b0, state_dbg}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int i = 0; i < nvec; i++) begin
            run_op(vecs[i]);
        end

        // Reset while RUN with cnt=2: operation dropped, no result.
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrun_state", {30'b0, state_dbg}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_rst_flags", {29'b0, in_ready, out_valid, busy}, 32'h4);
        check("midrun_rst_sum", {15'b0, cout, sum}, 32'd0);
        tick();
        check("midrun_no_out", {31'b0, out_valid}, 32'd0);
        run_op('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 0});

        // Back-to-back: in_valid held, out_ready held; accepts spaced NIBBLES+2 apart.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'h0001;
        b         = 16'h0002;
        cin       = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) acc_cyc.push_back(c);
            if (out_valid) check("b2b_sum", {15'b0, cout, sum}, 32'h3);
            tick();
        end
        in_valid = 1'b0;
        repeat (NIB + 3) tick();
        out_ready = 1'b0;
        check("b2b_count_ok", {31'b0, 1'(acc_cyc.size() >= 4)}, 32'd1);
        for (int k = 1; k < acc_cyc.size() && k < 4; k++) begin
            check("b2b_gap", acc_cyc[k] - acc_cyc[k-1], NIB + 2);
        end

        // WIDTH=4 instance: single pass, 9 + 8 = 0x11.
        check("w4_ready", {31'b0, in_ready4}, 32'd1);
        in_valid4 = 1'b1;
        a4        = 4'h9;
        b4        = 4'h8;
        cin4      = 1'b0;
        tick();
        in_valid4 = 1'b0;
        tick();
        check("w4_valid", {31'b0, out_valid4}, 32'd1);
        check("w4_result", {27'b0, cout4, sum4}, 32'h11);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("w4_release", {30'b0, out_valid4, in_ready4}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
